delay_tap_scheduler: RTL and testbench

Parametrised successor to the single-bank local-controller delay table. It holds per-object delay entries in two banks: an active bank and a shadow bank. Each entry is converted into a tapping-location packet and a destination block index. Shadow updates from the global scenario NoC are swapped in atomically at scenario boundaries, and the valid entries are re-emitted after every start or swap. It sits between the global-scenario NoC input and the prefetch/tap logic of a local controller.

---
 rtl/delay_tap_scheduler_pkg.sv | 32 +++
 rtl/delay_tap_scheduler_bank.sv | 43 ++++
 rtl/delay_tap_scheduler.sv | 180 ++++++++++++++++++
 tb/tb_delay_tap_scheduler.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/delay_tap_scheduler_pkg.sv
// Shared types for the delay tap scheduler: default widths, FSM encoding,
// the stored table entry and the tap packet layout.
package delay_tap_scheduler_pkg;

    localparam int DEF_N_OBJ             = 4;
    localparam int DEF_OBJ_ID_WIDTH      = 2;
    localparam int DEF_DELAY_LENGTH      = 14;
    localparam int DEF_SAMPLE_ADDR_WIDTH = 10;
    localparam int DEF_DEST_WIDTH        = 4;
    localparam int DEF_SCEN_LEN_WIDTH    = 13;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_EMIT = 2'd2
    } state_e;

    typedef struct packed {
        logic                        valid;
        logic                        underflow;
        logic [DEF_DELAY_LENGTH-1:0] adj;
    } entry_t;

    // Packet is {sample address, object id}; the destination bits travel separately.
    function automatic logic [DEF_SAMPLE_ADDR_WIDTH+DEF_OBJ_ID_WIDTH-1:0] make_packet(
        input logic [DEF_DELAY_LENGTH-1:0] adj,
        input logic [DEF_OBJ_ID_WIDTH-1:0] obj_id
    );
        return {adj[DEF_SAMPLE_ADDR_WIDTH-1:0], obj_id};
    endfunction

endpackage

// File: rtl/delay_tap_scheduler_bank.sv
// One bank of delay entries: indexed write, combinational read, clear-all.
// A write to an entry in the same cycle as a clear keeps the written entry.
module delay_tap_bank
    import delay_tap_scheduler_pkg::*;
#(
    parameter int N_OBJ        = DEF_N_OBJ,
    parameter int OBJ_ID_WIDTH = DEF_OBJ_ID_WIDTH
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    clear_i,
    input  logic                    we_i,
    input  logic [OBJ_ID_WIDTH-1:0] waddr_i,
    input  entry_t                  wdata_i,
    input  logic [OBJ_ID_WIDTH-1:0] raddr_i,
    output entry_t                  rdata_o,
    output logic                    any_valid_o
);

    entry_t mem_q [N_OBJ];

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < N_OBJ; i++) begin
            if (rst_i) begin
                mem_q[i] <= '0;
            end else if (we_i && (waddr_i == OBJ_ID_WIDTH'(i))) begin
                mem_q[i] <= wdata_i;
            end else if (clear_i) begin
                mem_q[i] <= '0;
            end
        end
    end

    assign rdata_o = mem_q[raddr_i];

    always_comb begin
        any_valid_o = 1'b0;
        for (int i = 0; i < N_OBJ; i++) begin
            any_valid_o = any_valid_o | mem_q[i].valid;
        end
    end

endmodule

// File: rtl/delay_tap_scheduler.sv
// Two-bank delay table: boot writes fill the active bank, runtime writes fill
// the shadow bank, which is swapped in at a scenario wrap and then re-emitted.
module delay_tap_scheduler
    import delay_tap_scheduler_pkg::*;
#(
    parameter int N_OBJ             = DEF_N_OBJ,
    parameter int OBJ_ID_WIDTH      = DEF_OBJ_ID_WIDTH,
    parameter int DELAY_LENGTH      = DEF_DELAY_LENGTH,
    parameter int SAMPLE_ADDR_WIDTH = DEF_SAMPLE_ADDR_WIDTH,
    parameter int DEST_WIDTH        = DEF_DEST_WIDTH,
    parameter int SCEN_LEN_WIDTH    = DEF_SCEN_LEN_WIDTH
) (
    input  logic                                      CLK,
    input  logic                                      reset,
    input  logic                                      boot_up,
    input  logic                                      input_valid,
    input  logic                                      glob_scen_noc_input_valid,
    input  logic [DELAY_LENGTH-1:0]                   delay_matrix_element,
    input  logic [OBJ_ID_WIDTH-1:0]                   obj_id_element,
    input  logic [DELAY_LENGTH-1:0]                   hardware_latency1,
    input  logic [DELAY_LENGTH-1:0]                   hardware_latency2,
    input  logic [SCEN_LEN_WIDTH-1:0]                 scenario_len,
    input  logic                                      start,
    output logic [SAMPLE_ADDR_WIDTH+OBJ_ID_WIDTH-1:0] tapping_loc_packet,
    output logic [DEST_WIDTH-1:0]                     tap_dest,
    output logic                                      tapping_loc_valid,
    output logic                                      tap_underflow,
    output logic [SCEN_LEN_WIDTH-1:0]                 scenario_counter,
    output logic                                      scenario_update,
    output logic                                      table_ready
);

    state_e                                   state_q, state_d;
    logic [SCEN_LEN_WIDTH-1:0]                counter_q, counter_d;
    logic [OBJ_ID_WIDTH-1:0]                  slot_q, slot_d;
    logic                                     bank_sel_q, bank_sel_d;
    logic                                     dirty_q, dirty_d;
    logic [SAMPLE_ADDR_WIDTH+OBJ_ID_WIDTH-1:0] packet_q, packet_d;
    logic [DEST_WIDTH-1:0]                    dest_q, dest_d;
    logic                                     tvalid_q, tvalid_d;
    logic                                     uflow_q, uflow_d;
    logic                                     update_q, update_d;
    logic                                     ready_q;

    logic [DELAY_LENGTH+1:0]   adj_full;
    entry_t                    new_entry;
    logic                      boot_we, rt_we, swap, wrap, rt_target;
    logic [SCEN_LEN_WIDTH-1:0] len_last;
    logic [1:0]                bank_we, bank_clr, bank_any;
    entry_t                    rd0, rd1, act_entry;

    // Two guard bits so the double subtraction cannot wrap past the sign.
    assign adj_full = {2'b00, delay_matrix_element} - {2'b00, hardware_latency1}
                    - {2'b00, hardware_latency2};

    always_comb begin
        new_entry           = '0;
        new_entry.valid     = 1'b1;
        new_entry.underflow = adj_full[DELAY_LENGTH+1];
        new_entry.adj       = adj_full[DELAY_LENGTH+1] ? '0 : adj_full[DELAY_LENGTH-1:0];
    end

    assign rt_we   = glob_scen_noc_input_valid;
    assign boot_we = boot_up & input_valid & ~rt_we & (state_q == ST_IDLE);

    assign len_last = (scenario_len == '0) ? '0 : scenario_len - SCEN_LEN_WIDTH'(1);
    assign wrap     = (counter_q == len_last);

    always_comb begin
        state_d  = state_q;
        counter_d = counter_q;
        slot_d   = slot_q;
        swap     = 1'b0;
        update_d = 1'b0;
        if (start) begin
            state_d   = ST_EMIT;
            counter_d = '0;
            slot_d    = '0;
        end else begin
            case (state_q)
                ST_IDLE: ;
                ST_RUN, ST_EMIT: begin
                    if (wrap) begin
                        counter_d = '0;
                        update_d  = 1'b1;
                        swap      = dirty_q;
                        if (dirty_q || (state_q == ST_EMIT)) begin
                            state_d = ST_EMIT;
                            slot_d  = '0;
                        end
                    end else begin
                        counter_d = counter_q + SCEN_LEN_WIDTH'(1);
                        if (state_q == ST_EMIT) begin
                            if (slot_q == OBJ_ID_WIDTH'(N_OBJ - 1)) begin
                                state_d = ST_RUN;
                            end else begin
                                slot_d = slot_q + OBJ_ID_WIDTH'(1);
                            end
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // A runtime write in the swap cycle targets the bank that becomes shadow.
    assign rt_target  = swap ? bank_sel_q : ~bank_sel_q;
    assign bank_sel_d = swap ? ~bank_sel_q : bank_sel_q;
    assign dirty_d    = rt_we ? 1'b1 : (swap ? 1'b0 : dirty_q);

    assign bank_we[0]  = (boot_we & ~bank_sel_q) | (rt_we & ~rt_target);
    assign bank_we[1]  = (boot_we &  bank_sel_q) | (rt_we &  rt_target);
    assign bank_clr[0] = swap & ~bank_sel_q;
    assign bank_clr[1] = swap &  bank_sel_q;

    delay_tap_bank #(.N_OBJ(N_OBJ), .OBJ_ID_WIDTH(OBJ_ID_WIDTH)) u_bank0 (
        .clk_i(CLK), .rst_i(reset), .clear_i(bank_clr[0]), .we_i(bank_we[0]),
        .waddr_i(obj_id_element), .wdata_i(new_entry), .raddr_i(slot_q),
        .rdata_o(rd0), .any_valid_o(bank_any[0])
    );

    delay_tap_bank #(.N_OBJ(N_OBJ), .OBJ_ID_WIDTH(OBJ_ID_WIDTH)) u_bank1 (
        .clk_i(CLK), .rst_i(reset), .clear_i(bank_clr[1]), .we_i(bank_we[1]),
        .waddr_i(obj_id_element), .wdata_i(new_entry), .raddr_i(slot_q),
        .rdata_o(rd1), .any_valid_o(bank_any[1])
    );

    assign act_entry = bank_sel_q ? rd1 : rd0;

    always_comb begin
        tvalid_d = 1'b0;
        packet_d = '0;
        dest_d   = '0;
        uflow_d  = 1'b0;
        if ((state_q == ST_EMIT) && act_entry.valid) begin
            tvalid_d = 1'b1;
            packet_d = make_packet(act_entry.adj, slot_q);
            dest_d   = act_entry.adj[DELAY_LENGTH-1:SAMPLE_ADDR_WIDTH];
            uflow_d  = act_entry.underflow;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            counter_q  <= '0;
            slot_q     <= '0;
            bank_sel_q <= 1'b0;
            dirty_q    <= 1'b0;
            packet_q   <= '0;
            dest_q     <= '0;
            tvalid_q   <= 1'b0;
            uflow_q    <= 1'b0;
            update_q   <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            counter_q  <= counter_d;
            slot_q     <= slot_d;
            bank_sel_q <= bank_sel_d;
            dirty_q    <= dirty_d;
            packet_q   <= packet_d;
            dest_q     <= dest_d;
            tvalid_q   <= tvalid_d;
            uflow_q    <= uflow_d;
            update_q   <= update_d;
            ready_q    <= bank_sel_q ? bank_any[1] : bank_any[0];
        end
    end

    assign tapping_loc_packet = packet_q;
    assign tap_dest           = dest_q;
    assign tapping_loc_valid  = tvalid_q;
    assign tap_underflow      = uflow_q;
    assign scenario_counter   = counter_q;
    assign scenario_update    = update_q;
    assign table_ready        = ready_q;

endmodule

// File: tb/tb_delay_tap_scheduler.sv
// Bench for delay_tap_scheduler: a table-level reference model checked every
// cycle, plus directed scenarios with literal expected packets.
module tb_delay_tap_scheduler;

    localparam int N  = 4;
    localparam int OW = 2;
    localparam int DL = 14;
    localparam int SA = 10;
    localparam int DW = 4;
    localparam int SW = 13;

    // clock / reset
    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic           reset = 1'b1;
    logic           boot_up = 1'b0, input_valid = 1'b0, glob_valid = 1'b0, start = 1'b0;
    logic [DL-1:0]  delay_el = '0, hl1 = '0, hl2 = '0;
    logic [OW-1:0]  obj_id = '0;
    logic [SW-1:0]  scenario_len = 13'd20;
    logic [SA+OW-1:0] tapping_loc_packet;
    logic [DW-1:0]  tap_dest;
    logic           tapping_loc_valid, tap_underflow, scenario_update, table_ready;
    logic [SW-1:0]  scenario_counter;

    delay_tap_scheduler dut (
        .CLK(CLK), .reset(reset), .boot_up(boot_up), .input_valid(input_valid),
        .glob_scen_noc_input_valid(glob_valid), .delay_matrix_element(delay_el),
        .obj_id_element(obj_id), .hardware_latency1(hl1), .hardware_latency2(hl2),
        .scenario_len(scenario_len), .start(start),
        .tapping_loc_packet(tapping_loc_packet), .tap_dest(tap_dest),
        .tapping_loc_valid(tapping_loc_valid), .tap_underflow(tap_underflow),
        .scenario_counter(scenario_counter), .scenario_update(scenario_update),
        .table_ready(table_ready)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: table contents plus phase (0 idle, 1 run, 2 emit)
    int a_v[N], a_u[N], a_adj[N];
    int s_v[N], s_u[N], s_adj[N];
    int m_dirty, m_mode, m_cnt, m_scan, model_live = 0;
    int e_valid, e_pkt, e_dest, e_uf, e_cnt, e_upd, e_ready;

    always @(posedge CLK) begin
        int w_adj, w_uf, len, boot_ok, do_swap;
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                a_v[i] = 0; a_u[i] = 0; a_adj[i] = 0; s_v[i] = 0; s_u[i] = 0; s_adj[i] = 0;
            end
            m_dirty = 0; m_mode = 0; m_cnt = 0; m_scan = 0;
            e_valid = 0; e_pkt = 0; e_dest = 0; e_uf = 0; e_cnt = 0; e_upd = 0; e_ready = 0;
            model_live = 1;
        end else if (model_live == 1) begin
            e_ready = 0;
            for (int i = 0; i < N; i++) if (a_v[i] == 1) e_ready = 1;
            e_valid = 0; e_pkt = 0; e_dest = 0; e_uf = 0; e_upd = 0;
            if (m_mode == 2 && a_v[m_scan] == 1) begin
                e_valid = 1;
                e_pkt   = (a_adj[m_scan] % 1024) * 4 + m_scan;
                e_dest  = a_adj[m_scan] / 1024;
                e_uf    = a_u[m_scan];
            end
            w_adj = int'(delay_el) - int'(hl1) - int'(hl2);
            w_uf  = (w_adj < 0) ? 1 : 0;
            if (w_uf == 1) w_adj = 0;
            boot_ok = (boot_up && input_valid && !glob_valid && m_mode == 0) ? 1 : 0;
            len = (scenario_len == 0) ? 1 : int'(scenario_len);
            do_swap = 0;
            if (start) begin
                m_mode = 2; m_cnt = 0; m_scan = 0;
            end else if (m_mode != 0) begin
                if (m_cnt == len - 1) begin
                    m_cnt = 0; e_upd = 1;
                    if (m_dirty == 1) do_swap = 1;
                    if (m_dirty == 1 || m_mode == 2) begin m_mode = 2; m_scan = 0; end
                end else begin
                    m_cnt = (m_cnt + 1) % 8192;
                    if (m_mode == 2) begin
                        if (m_scan == N - 1) m_mode = 1;
                        else m_scan = m_scan + 1;
                    end
                end
            end
            if (boot_ok == 1) begin a_v[obj_id] = 1; a_u[obj_id] = w_uf; a_adj[obj_id] = w_adj; end
            if (do_swap == 1) begin
                for (int i = 0; i < N; i++) begin
                    a_v[i] = s_v[i]; a_u[i] = s_u[i]; a_adj[i] = s_adj[i]; s_v[i] = 0;
                end
                m_dirty = 0;
            end
            if (glob_valid) begin
                s_v[obj_id] = 1; s_u[obj_id] = w_uf; s_adj[obj_id] = w_adj; m_dirty = 1;
            end
            e_cnt = m_cnt;
        end
    end

    // compare process
    always @(negedge CLK) begin
        if (model_live == 1) begin
            check("m_valid",   tapping_loc_valid,  e_valid);
            check("m_packet",  tapping_loc_packet, e_pkt);
            check("m_dest",    tap_dest,           e_dest);
            check("m_uflow",   tap_underflow,      e_uf);
            check("m_counter", scenario_counter,   e_cnt);
            check("m_update",  scenario_update,    e_upd);
            check("m_ready",   table_ready,        e_ready);
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic boot_write(input int id, input int d);
        boot_up = 1'b1; input_valid = 1'b1; obj_id = OW'(id); delay_el = DL'(d);
        tick();
        boot_up = 1'b0; input_valid = 1'b0;
    endtask

    task automatic rt_write(input int id, input int d);
        glob_valid = 1'b1; obj_id = OW'(id); delay_el = DL'(d);
        tick();
        glob_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_counter(input int val, input int budget);
        int n = 0;
        while (scenario_counter != SW'(val) && n < budget) begin
            tick();
            n++;
        end
        check("wait_counter", scenario_counter, val);
    endtask

    task automatic expect_pkt(input string name, input int v, input int pkt, input int dest);
        check({name, "_valid"}, tapping_loc_valid, v);
        if (v == 1) begin
            check({name, "_pkt"},  tapping_loc_packet, pkt);
            check({name, "_dest"}, tap_dest, dest);
        end
    endtask

    initial begin
        int n;
        tick(); tick();
        reset = 1'b0;
        check("rst_valid", tapping_loc_valid, 0);
        check("rst_ready", table_ready, 0);
        check("rst_counter", scenario_counter, 0);

        // boot load and first emission
        boot_write(1, 10000);
        boot_write(0, 10010);
        boot_write(2, 12000);
        pulse_start();
        tick(); expect_pkt("t1_s0", 1, 3176, 9);
        check("t1_cnt", scenario_counter, 1);
        tick(); expect_pkt("t1_s1", 1, 3137, 9);
        tick(); expect_pkt("t1_s2", 1, 2946, 11);
        tick(); expect_pkt("t1_s3", 0, 0, 0);
        check("t1_ready", table_ready, 1);

        // shadow update swapped in at the wrap
        tick();
        check("t3_cnt5", scenario_counter, 5);
        rt_write(0, 10008);
        n = 0;
        while (!scenario_update && n < 40) begin
            check("t3_no_emit", tapping_loc_valid, 0);
            tick();
            n++;
        end
        check("t3_update", scenario_update, 1);
        check("t3_wrap_cnt", scenario_counter, 0);
        tick(); expect_pkt("t3_s0", 1, 3168, 9);
        tick(); expect_pkt("t3_s1", 0, 0, 0);
        tick(); expect_pkt("t3_s2", 0, 0, 0);

        // runtime write landing in the swap cycle
        rt_write(3, 10008);
        wait_counter(19, 40);
        rt_write(1, 10000);
        check("t4_update", scenario_update, 1);
        tick(); expect_pkt("t4_s0", 0, 0, 0);
        tick(); expect_pkt("t4_s1", 0, 0, 0);
        tick(); tick(); expect_pkt("t4_s3", 1, 3171, 9);
        wait_counter(19, 40);
        tick();
        check("t4_update2", scenario_update, 1);
        tick(); expect_pkt("t4b_s0", 0, 0, 0);
        tick(); expect_pkt("t4b_s1", 1, 3137, 9);

        // underflow clamp
        reset = 1'b1; tick(); reset = 1'b0;
        hl1 = DL'(100);
        boot_write(0, 50);
        hl1 = '0;
        pulse_start();
        tick(); expect_pkt("t2_s0", 1, 0, 0);
        check("t2_uflow", tap_underflow, 1);

        // boot write outside IDLE is ignored; zero length wraps every cycle
        tick(); tick(); tick(); tick();
        boot_write(1, 12000);
        pulse_start();
        tick(); tick(); expect_pkt("t5_s1", 0, 0, 0);
        scenario_len = '0;
        pulse_start();
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t5_update", scenario_update, 1);
            check("t5_cnt", scenario_counter, 0);
        end

        // reset in the middle of an emission
        scenario_len = 13'd20;
        pulse_start();
        tick();
        reset = 1'b1; tick(); reset = 1'b0;
        check("t6_valid", tapping_loc_valid, 0);
        check("t6_ready", table_ready, 0);
        check("t6_update", scenario_update, 0);
        check("t6_cnt", scenario_counter, 0);
        pulse_start();
        for (int i = 0; i < 6; i++) begin
            tick();
            check("t6_no_pkt", tapping_loc_valid, 0);
        end

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
